// File: rtl/iter_barrel_shifter_if.sv
// Handshake bundle for iter_barrel_shifter: request operands in, status and result out.
`timescale 1ns/1ps
interface iter_barrel_shifter_if #(parameter int N = 3);
  logic               start;
  logic [(2**N)-1:0]  A;
  logic [N-1:0]       AMT;
  logic               dir;
  logic               rot;
  logic               busy;
  logic               done;
  logic [(2**N)-1:0]  Y;

  modport master (output start, output A, output AMT, output dir, output rot,
                  input busy, input done, input Y);
  modport slave  (input start, input A, input AMT, input dir, input rot,
                  output busy, output done, output Y);
endinterface

// File: rtl/iter_barrel_shifter.sv
// Multi-cycle shifter/rotator: one logarithmic stage per clock, N stages per operation.
// Left operations run through the right-shift datapath with bit reversal on load and unload.
`timescale 1ns/1ps
module iter_barrel_shifter #(
  parameter int N = 3
) (
  input logic clk,
  input logic reset_n,
  iter_barrel_shifter_if.slave bus
);
  localparam int W  = 2**N;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   stage_r, stage_s;
  logic [W-1:0]    work_r, work_s;
  logic [W-1:0]    y_r, y_s;
  logic [N-1:0]    amt_r, amt_s;
  logic            dir_r, dir_s;
  logic            rot_r, rot_s;
  logic            busy_r, done_r;
  logic [W-1:0]    step_s;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = v[W-1-i];
    end
    return r;
  endfunction

  // Right shift by 2**st; the doubled word supplies either the wrapped bits or zeros.
  function automatic logic [W-1:0] shr_stage(input logic [W-1:0] v,
                                             input logic [SW-1:0] st,
                                             input logic wrap);
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] sh;
    dbl = wrap ? {v, v} : {{W{1'b0}}, v};
    sh  = dbl >> (32'd1 << st);
    return sh[W-1:0];
  endfunction

  assign step_s = amt_r[stage_r] ? shr_stage(work_r, stage_r, rot_r) : work_r;

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    work_s  = work_r;
    amt_s   = amt_r;
    dir_s   = dir_r;
    rot_s   = rot_r;
    y_s     = y_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          amt_s   = bus.AMT;
          dir_s   = bus.dir;
          rot_s   = bus.rot;
          work_s  = bus.dir ? bitrev(bus.A) : bus.A;
          stage_s = {SW{1'b0}};
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s = step_s;
        if (stage_r == SW'(N - 1)) begin
          y_s     = dir_r ? bitrev(step_s) : step_s;
          stage_s = {SW{1'b0}};
          state_s = DONE;
        end else begin
          stage_s = stage_r + SW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      stage_r <= {SW{1'b0}};
      work_r  <= {W{1'b0}};
      amt_r   <= {N{1'b0}};
      dir_r   <= 1'b0;
      rot_r   <= 1'b0;
      y_r     <= {W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      stage_r <= stage_s;
      work_r  <= work_s;
      amt_r   <= amt_s;
      dir_r   <= dir_s;
      rot_r   <= rot_s;
      y_r     <= y_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Y    = y_r;
endmodule

// File: tb/tb_iter_barrel_shifter.sv
// Self-checking bench for iter_barrel_shifter (N = 3): directed cases plus randomized
// operations compared against an arithmetic shift/rotate reference.
`timescale 1ns/1ps
module tb_iter_barrel_shifter;
  localparam int N = 3;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  iter_barrel_shifter_if #(.N(N)) bus ();

  iter_barrel_shifter #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shifts and rotates by plain integer arithmetic on an 8-bit word.
  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int amt,
                                           input logic d, input logic r);
    int x;
    int res;
    x = int'(a);
    if (!d) res = (x >> amt) | (r ? (x << (8 - amt)) : 0);
    else    res = (x << amt) | (r ? (x >> (8 - amt)) : 0);
    return res[7:0];
  endfunction

  // Issue one operation, scramble inputs after capture, wait for done (bounded).
  task automatic do_op(input logic [7:0] a, input logic [2:0] amt, input logic d,
                       input logic r, output logic [7:0] y, output int lat,
                       output int busy_cnt);
    bus.A = a; bus.AMT = amt; bus.dir = d; bus.rot = r; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = 8'($urandom); bus.AMT = 3'($urandom); bus.dir = 1'($urandom); bus.rot = 1'($urandom);
    lat = -1; busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    y = bus.Y;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.A = 8'h00; bus.AMT = 3'd0; bus.dir = 1'b0; bus.rot = 1'b0;
    reset_n = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.Y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", bus.Y); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] a_t [6];
    logic [2:0] m_t [6];
    logic       d_t [6];
    logic       r_t [6];
    logic [7:0] e_t [6];
    logic [7:0] y;
    int lat, bc;
    a_t = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96};
    m_t = '{3'd3, 3'd3, 3'd1, 3'd3, 3'd0, 3'd0};
    d_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    r_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e_t = '{8'h12, 8'hB0, 8'h2D, 8'hD2, 8'h96, 8'h96};
    for (int i = 0; i < 6; i++) begin
      do_op(a_t[i], m_t[i], d_t[i], r_t[i], y, lat, bc);
      checks++; if (y !== e_t[i]) begin failures++; $display("FAIL dir_y[%0d] got=%h exp=%h", i, y, e_t[i]); end
      checks++; if (lat !== N) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, N); end
      checks++; if (bc !== N) begin failures++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", i, bc, N); end
      // done is a single-cycle pulse and Y holds afterwards
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir_done_pulse[%0d] got=%b exp=0", i, bus.done); end
      repeat (2) @(posedge clk); #1;
      checks++; if (bus.Y !== e_t[i]) begin failures++; $display("FAIL dir_y_hold[%0d] got=%h exp=%h", i, bus.Y, e_t[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, y, e;
    logic [2:0] m;
    logic d, r;
    int lat, bc;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); m = 3'($urandom); d = 1'($urandom); r = 1'($urandom);
      e = ref_shift(a, int'(m), d, r);
      do_op(a, m, d, r, y, lat, bc);
      checks++; if (y !== e) begin failures++; $display("FAIL rand_y[%0d] a=%h amt=%0d dir=%b rot=%b got=%h exp=%h", i, a, m, d, r, y, e); end
      checks++; if (lat !== N) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, N); end
    end
  endtask

  task automatic test_start_in_shift();
    int dones;
    logic [7:0] yd;
    bus.A = 8'hFF; bus.AMT = 3'd7; bus.dir = 1'b0; bus.rot = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.A = 8'h01; bus.AMT = 3'd2; bus.dir = 1'b1; bus.rot = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = 8'h5A;
    dones = 0; yd = 8'hxx;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) begin dones++; yd = bus.Y; end
      @(posedge clk); #1;
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (yd !== 8'h01) begin failures++; $display("FAIL ignore_y got=%h exp=01", yd); end
    checks++; if (bus.Y !== 8'h01) begin failures++; $display("FAIL ignore_y_hold got=%h exp=01", bus.Y); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    bus.A = 8'h81; bus.AMT = 3'd1; bus.dir = 1'b1; bus.rot = 1'b1; bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      exp_done = ((c % (N + 1)) == 0);
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", c, bus.done, exp_done); end
      checks++; if (bus.busy !== !exp_done) begin failures++; $display("FAIL b2b_busy[%0d] got=%b exp=%b", c, bus.busy, !exp_done); end
      if (exp_done) begin
        checks++; if (bus.Y !== 8'h03) begin failures++; $display("FAIL b2b_y[%0d] got=%h exp=03", c, bus.Y); end
      end
    end
    bus.start = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [7:0] y;
    int lat, bc, dones;
    do_op(8'h96, 3'd3, 1'b0, 1'b0, y, lat, bc);
    checks++; if (y !== 8'h12) begin failures++; $display("FAIL rst_pre_y got=%h exp=12", y); end
    @(posedge clk); #1;
    bus.A = 8'h55; bus.AMT = 3'd2; bus.dir = 1'b0; bus.rot = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.Y !== 8'h12) begin failures++; $display("FAIL rst_y_hold_in_shift got=%h exp=12", bus.Y); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", bus.done); end
    checks++; if (bus.Y !== 8'h00) begin failures++; $display("FAIL rst_mid_y got=%h exp=00", bus.Y); end
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    do_op(8'h0F, 3'd4, 1'b1, 1'b0, y, lat, bc);
    checks++; if (y !== 8'hF0) begin failures++; $display("FAIL rst_post_y got=%h exp=f0", y); end
    checks++; if (lat !== N) begin failures++; $display("FAIL rst_post_latency got=%0d exp=%0d", lat, N); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_in_shift();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
